tabla_verdad_seq: RTL and testbench
===================================

# tabla_verdad_seq

Programmable, registered N-input truth-table evaluator: the sequential successor to the team's fixed gate-level and operator-level logic functions. A loaded 2^N-bit truth table replaces hard-wired equations. The block either evaluates external inputs every cycle (direct mode) or sweeps all 2^N input combinations itself (sweep mode), emitting one row per cycle and reporting the minterm count. It sits between the lab's switch/stimulus logic and the display/checker logic.

## Interface
Parameters:
- N, default 4: number of function inputs; legal range 1..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- tabla  in  2^N  truth table; bit i = function value for input combination i (in_vec[N-1] = A = MSB).
- load  in  1  capture tabla into internal tabla_r; honoured only in IDLE.
- mode  in  1  0 = direct, 1 = sweep; sampled only in IDLE.
- in_vec  in  N  direct-mode input combination.
- start  in  1  begin a sweep; honoured only in IDLE with mode=1.
- pause  in  1  stall the sweep counter.
- out  out  1  registered function value.
- row  out  N  input combination that produced out.
- out_valid  out  1  out/row are valid this cycle.
- busy  out  1  high in SWEEP and DONE (decode of the state register).
- done  out  1  one-cycle pulse at sweep completion.
- ones_count  out  N+1  number of 1-rows in the last completed sweep.

## Operation
- Reset (async, any state): state=IDLE, tabla_r=0, cnt=0, acc=0. Outputs: out=0, row=0, out_valid=0, busy=0, done=0, ones_count=0.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - load=1: tabla_r <= tabla.
  - mode=0: out <= tabla_r[in_vec], row <= in_vec, out_valid <= 1.
  - mode=1, start=0: out_valid <= 0; out and row hold.
  - mode=1, start=1: go to SWEEP; cnt <= 0, acc <= 0, out_valid <= 0.
  - load and start on the same edge: the sweep uses the newly loaded table.
- SWEEP, pause=0, on each edge:
  - out <= tabla_r[cnt], row <= cnt, out_valid <= 1, acc <= acc + tabla_r[cnt].
  - If cnt = 2^N-1, go to DONE; otherwise cnt <= cnt+1.
- SWEEP, pause=1: out_valid <= 0; cnt, acc, out and row hold.
- DONE (one cycle): ones_count <= acc, done <= 1, out_valid <= 0, go to IDLE.
- done clears on the next edge.
- Ignored while busy: start, load, mode and in_vec. A sweep always runs to completion unless reset is asserted.
- Width rules:
  - acc and ones_count are N+1 bits. The maximum value 2^N must not wrap.
  - cnt is N bits and never wraps past 2^N-1.
- Reset during a sweep: everything returns to reset values, no done pulse, ones_count=0.

## Timing
- Direct mode latency: 1 cycle, in_vec to out/row/out_valid.
- Sweep with start sampled at edge k and no pause:
  - row j is valid after edge k+1+j, for j = 0..2^N-1.
  - done=1 and the final ones_count appear after edge k+2^N+1; busy=0 from that same edge.
  - done and busy never overlap.
- Each paused cycle delays all later rows and done by exactly one cycle.
- pause has no effect outside SWEEP.

## Test plan
All scenarios use N=3. tabla=8'h33 implements out = ~B.
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately (asynchronous); after release, out_valid=0 until the first valid operation.
2. Direct mode: load 8'h33, mode=0.
   - in_vec=3'b010 -> out=0, row=2 one cycle later.
   - in_vec=3'b101 -> out=1, row=5.
3. Sweep: load 8'h33, start at edge k.
   - After edges k+1..k+8: rows 0..7 with out = 1,1,0,0,1,1,0,0, out_valid=1.
   - After edge k+9: done=1 for one cycle, ones_count=4, busy=0.
4. Pause: hold pause=1 for 2 cycles after row 3 is output -> out_valid=0 for 2 cycles, then row 4 resumes; done at edge k+11; ones_count=4.
5. Busy lockout and same-edge load:
   - During a sweep, pulse start and load with tabla=8'hFF -> no effect; ones_count=4.
   - Then load=1 with 8'hFF and start=1 on the same edge -> all 8 rows out=1; ones_count=8 (full-width value, no wrap).
6. Reset mid-sweep at row 4 -> no done, ones_count=0, tabla_r=0. A new load 8'h33 plus start -> full 8-row sweep, ones_count=4.

Source files
------------

// File: rtl/tabla_verdad_seq.sv
// Programmable N-input truth-table evaluator with a direct mode that looks up in_vec
// each cycle, and a sweep mode that walks every row and reports the minterm count.
module tabla_verdad_seq #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [(1<<N)-1:0] tabla,
    input  logic              load,
    input  logic              mode,
    input  logic [N-1:0]      in_vec,
    input  logic              start,
    input  logic              pause,
    output logic              out,
    output logic [N-1:0]      row,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [N:0]        ones_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N-1:0] LAST_ROW = '1;

    logic [1:0]        state_q, state_d;
    logic [(1<<N)-1:0] tabla_q, tabla_d;
    logic [N-1:0]      cnt_q, cnt_d;
    logic [N:0]        acc_q, acc_d;
    logic              out_q, out_d;
    logic [N-1:0]      row_q, row_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic [N:0]        ones_q, ones_d;

    always_comb begin
        state_d = state_q;
        tabla_d = tabla_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        row_d   = row_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                // Loading and starting on one edge is fine: the first row is read
                // one edge later, after the new table has landed.
                if (load) tabla_d = tabla;
                if (!mode) begin
                    out_d = tabla_q[in_vec];
                    row_d = in_vec;
                    vld_d = 1'b1;
                end else if (start) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_SWEEP: begin
                if (!pause) begin
                    out_d = tabla_q[cnt_q];
                    row_d = cnt_q;
                    vld_d = 1'b1;
                    acc_d = acc_q + {{N{1'b0}}, tabla_q[cnt_q]};
                    if (cnt_q == LAST_ROW) state_d = S_DONE;
                    else                   cnt_d   = cnt_q + N'(1);
                end
            end
            S_DONE: begin
                ones_d  = acc_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tabla_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= 1'b0;
            row_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            tabla_q <= tabla_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            row_q   <= row_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
        end
    end

    // busy drops on the same edge that raises done, so the two never overlap.
    assign busy       = (state_q == S_SWEEP) || (state_q == S_DONE);
    assign out        = out_q;
    assign row        = row_q;
    assign out_valid  = vld_q;
    assign done       = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_tabla_verdad_seq.sv
// Directed bench for tabla_verdad_seq at N=3; tabla 8'h33 is out = ~B.
module tb_tabla_verdad_seq;

    localparam int N = 3;

    logic           clk;
    logic           rst_n;
    logic [7:0]     tabla;
    logic           load;
    logic           mode;
    logic [N-1:0]   in_vec;
    logic           start;
    logic           pause;
    logic           out;
    logic [N-1:0]   row;
    logic           out_valid;
    logic           busy;
    logic           done;
    logic [N:0]     ones_count;

    int total = 0;
    int bad   = 0;

    tabla_verdad_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tabla      (tabla),
        .load       (load),
        .mode       (mode),
        .in_vec     (in_vec),
        .start      (start),
        .pause      (pause),
        .out        (out),
        .row        (row),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects start to have been sampled at the last tick. pause_at: row after which
    // pause is held for plen cycles (-1 = none). poke_at: row after which start/load/
    // mode/in_vec are disturbed for one cycle (-1 = none).
    task automatic sweep(input logic [7:0] tab, input int pause_at, input int plen,
                         input int poke_at, input logic [N:0] exp_ones);
        logic [7:0] t;
        t = tab;
        chk("sweep_busy_start", {31'd0, busy}, 32'd1);
        chk("sweep_vld_start", {31'd0, out_valid}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            load  = 1'b0;
            start = 1'b0;
            mode  = 1'b1;
            chk($sformatf("row%0d", j), {29'd0, row}, j);
            chk($sformatf("out%0d", j), {31'd0, out}, {31'd0, t[j]});
            chk($sformatf("vld%0d", j), {31'd0, out_valid}, 32'd1);
            chk($sformatf("done_low%0d", j), {31'd0, done}, 32'd0);
            if (j == pause_at) begin
                pause = 1'b1;
                for (int p = 0; p < plen; p++) begin
                    tick();
                    chk($sformatf("pause_vld%0d", p), {31'd0, out_valid}, 32'd0);
                    chk($sformatf("pause_row%0d", p), {29'd0, row}, j);
                    chk($sformatf("pause_busy%0d", p), {31'd0, busy}, 32'd1);
                end
                pause = 1'b0;
            end
            if (j == poke_at) begin
                tabla  = 8'hFF;
                load   = 1'b1;
                start  = 1'b1;
                mode   = 1'b0;
                in_vec = 3'd7;
            end
        end
        chk("pre_done_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_vld", {31'd0, out_valid}, 32'd0);
        chk("ones_count", {28'd0, ones_count}, {28'd0, exp_ones});
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("ones_hold", {28'd0, ones_count}, {28'd0, exp_ones});
    endtask

    initial begin
        rst_n  = 1'b0;
        tabla  = 8'h00;
        load   = 1'b0;
        mode   = 1'b1;
        in_vec = '0;
        start  = 1'b0;
        pause  = 1'b0;
        tick();
        tick();
        chk("rst_out", {31'd0, out}, 32'd0);
        chk("rst_row", {29'd0, row}, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ones", {28'd0, ones_count}, 32'd0);
        rst_n = 1'b1;

        // Direct mode
        tabla = 8'h33;
        load  = 1'b1;
        tick();
        load = 1'b0;
        chk("idle_vld", {31'd0, out_valid}, 32'd0);
        mode   = 1'b0;
        in_vec = 3'b010;
        tick();
        chk("dir2_out", {31'd0, out}, 32'd0);
        chk("dir2_row", {29'd0, row}, 32'd2);
        chk("dir2_vld", {31'd0, out_valid}, 32'd1);
        in_vec = 3'b101;
        tick();
        chk("dir5_out", {31'd0, out}, 32'd1);
        chk("dir5_row", {29'd0, row}, 32'd5);
        chk("dir5_vld", {31'd0, out_valid}, 32'd1);
        pause = 1'b1;
        in_vec = 3'b011;
        tick();
        chk("dir_pause_ignored", {31'd0, out_valid}, 32'd1);
        chk("dir3_out", {31'd0, out}, 32'd0);
        pause = 1'b0;

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", {31'd0, out}, 32'd0);
        chk("arst_row", {29'd0, row}, 32'd0);
        chk("arst_vld", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        mode = 1'b1;
        tick();
        chk("post_rst_vld", {31'd0, out_valid}, 32'd0);

        // Plain sweep
        tabla = 8'h33;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep(8'h33, -1, 0, -1, 4'd4);

        // Pause for 2 cycles after row 3
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep(8'h33, 3, 2, -1, 4'd4);

        // Lockout: start/load/mode/in_vec poked mid-sweep do nothing
        start = 1'b1;
        tick();
        start = 1'b0;
        sweep(8'h33, -1, 0, 1, 4'd4);

        // Same-edge load and start, all-ones table: ones_count reaches 8 without wrap
        tabla = 8'hFF;
        load  = 1'b1;
        start = 1'b1;
        mode  = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        sweep(8'hFF, -1, 0, -1, 4'd8);

        // Reset mid-sweep at row 4
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        chk("mid_row4", {29'd0, row}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ones", {28'd0, ones_count}, 32'd0);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("mid_no_done%0d", j), {31'd0, done}, 32'd0);
        end
        chk("mid_ones_zero", {28'd0, ones_count}, 32'd0);
        // Cleared table: combination 0 now reads 0 (it was 1 under both 33 and FF)
        mode   = 1'b0;
        in_vec = 3'd0;
        tick();
        chk("mid_tab_cleared", {31'd0, out}, 32'd0);
        chk("mid_tab_vld", {31'd0, out_valid}, 32'd1);
        mode  = 1'b1;
        tabla = 8'h33;
        load  = 1'b1;
        start = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        sweep(8'h33, -1, 0, -1, 4'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
